// File: rtl/obi_sram_banked_ctrl_pkg.sv
// Shared types and helpers for the banked OBI SRAM controller: field-width
// helpers and the per-port response pipeline entry.
package obi_sram_banked_ctrl_pkg;

    // Upper bounds for the response-entry fields; legality is checked in the top.
    localparam int unsigned MaxBankW  = 4;
    localparam int unsigned MaxMacroW = 8;
    localparam int unsigned MaxIdW    = 8;

    // Width of an index register for n items; never zero so vectors stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [MaxBankW-1:0]  bank;
        logic [MaxMacroW-1:0] macro;
        logic [MaxIdW-1:0]    id;
    } resp_entry_t;

endpackage

// File: rtl/obi_bank_rr_arbiter.sv
// Per-bank round-robin arbiter: the search starts at the pointer, and the
// pointer moves to one past the winner. No grants are issued during reset.
module obi_bank_rr_arbiter
    import obi_sram_banked_ctrl_pkg::*;
#(
    parameter int unsigned NumPorts = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] req_i,
    output logic [NumPorts-1:0] gnt_o
);

    localparam int unsigned PtrW = idx_w(NumPorts);

    logic [PtrW-1:0] ptr_q, ptr_d, winner;
    logic [PtrW:0]   cand;
    logic            found;

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) ptr_d = (winner == PtrW'(NumPorts - 1)) ? '0 : winner + 1'b1;
    end

    // Rotate the request vector by the pointer, first hit wins.
    always_comb begin
        gnt_o  = '0;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = {1'b0, ptr_q} + (PtrW+1)'(i);
            if (cand >= (PtrW+1)'(NumPorts)) cand = cand - (PtrW+1)'(NumPorts);
            if (!rst_i && !found && req_i[cand[PtrW-1:0]]) begin
                gnt_o[cand[PtrW-1:0]] = 1'b1;
                found                 = 1'b1;
                winner                = cand[PtrW-1:0];
            end
        end
    end

endmodule

// File: rtl/tc_sram.sv
// Single-port SRAM macro model with byte enables and 1..N cycle read latency.
// Writes land at the clock edge, so a read in the following cycle sees them.
module tc_sram #(
    parameter int unsigned NumWords  = 256,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Latency   = 1,
    localparam int unsigned AddrW    = $clog2(NumWords),
    localparam int unsigned BeW      = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrW-1:0]     addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeW-1:0]       be_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0]              mem [NumWords];
    logic [Latency-1:0][DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int i = 0; i < BeW; i++) begin
                    if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end else begin
                rdata_q[0] <= mem[addr_i];
            end
        end
        for (int s = 1; s < Latency; s++) rdata_q[s] <= rdata_q[s-1];
    end

    assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/obi_sram_banked_ctrl.sv
// Multi-port word-interleaved SRAM controller: per-bank round-robin
// arbitration, NumRows stacked macros per bank, in-order fixed-latency responses.
module obi_sram_banked_ctrl
    import obi_sram_banked_ctrl_pkg::*;
#(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned NumBanks      = 4,
    parameter int unsigned NumRows       = 2,
    parameter int unsigned WordsPerMacro = 256,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned IdWidth       = 2,
    parameter int unsigned SramLatency   = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumPorts-1:0]                   req_i,
    output logic [NumPorts-1:0]                   gnt_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumPorts-1:0]                   we_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0]  be_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumPorts-1:0][IdWidth-1:0]      aid_i,
    output logic [NumPorts-1:0]                   rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]    rdata_o,
    output logic [NumPorts-1:0][IdWidth-1:0]      rid_o,
    input  logic                                  conflict_clr_i,
    output logic [31:0]                           conflict_cnt_o
);

    localparam int unsigned BeW       = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(BeW);
    localparam int unsigned BankW     = $clog2(NumBanks);
    localparam int unsigned RowW      = $clog2(WordsPerMacro);
    localparam int unsigned MacroW    = $clog2(NumRows);
    localparam int unsigned BankIdxW  = idx_w(NumBanks);
    localparam int unsigned MacroIdxW = idx_w(NumRows);

    if (NumPorts < 1 || NumPorts > 8) begin : g_bad_ports
        $error("NumPorts must be 1..8");
    end
    if (!is_pow2(NumBanks) || NumBanks > 16) begin : g_bad_banks
        $error("NumBanks must be a power of 2 in 1..16");
    end
    if (!is_pow2(NumRows) || MacroIdxW > MaxMacroW) begin : g_bad_rows
        $error("NumRows must be a power of 2 that fits the response entry");
    end
    if (!is_pow2(WordsPerMacro) || WordsPerMacro < 2) begin : g_bad_words
        $error("WordsPerMacro must be a power of 2, at least 2");
    end
    if (!is_pow2(DataWidth) || DataWidth < 32) begin : g_bad_data
        $error("DataWidth must be a power of 2, at least 32");
    end
    if (SramLatency < 1 || SramLatency > 2) begin : g_bad_lat
        $error("SramLatency must be 1 or 2");
    end
    if (IdWidth < 1 || IdWidth > MaxIdW) begin : g_bad_id
        $error("IdWidth out of range");
    end
    if (AddrWidth < OffW + BankW + RowW + MacroW) begin : g_bad_addr
        $error("AddrWidth too small for the address split");
    end

    logic [NumPorts-1:0][AddrWidth-1:0] word_addr;
    logic [NumPorts-1:0][BankIdxW-1:0]  port_bank;
    logic [NumPorts-1:0][MacroIdxW-1:0] port_macro;
    logic [NumPorts-1:0][RowW-1:0]      port_row;

    logic [NumBanks-1:0][NumPorts-1:0]  bank_req, bank_gnt;
    logic [NumBanks-1:0]                bank_act, bank_we;
    logic [NumBanks-1:0][BeW-1:0]       bank_be;
    logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
    logic [NumBanks-1:0][RowW-1:0]      bank_row;
    logic [NumBanks-1:0][MacroIdxW-1:0] bank_macro;

    logic [NumBanks-1:0][NumRows-1:0][DataWidth-1:0] sram_rdata;

    resp_entry_t [NumPorts-1:0]                resp_new, resp_out;
    resp_entry_t [NumPorts-1:0][SramLatency:1] resp_q;

    logic        conflict;
    logic [31:0] conflict_cnt_q;

    // Word address = byte address without the offset; the shifts/masks make
    // zero-width bank or macro fields collapse to index 0.
    always_comb begin
        word_addr  = '0;
        port_bank  = '0;
        port_row   = '0;
        port_macro = '0;
        for (int p = 0; p < NumPorts; p++) begin
            word_addr[p]  = addr_i[p] >> OffW;
            port_bank[p]  = BankIdxW'(word_addr[p] & AddrWidth'(NumBanks - 1));
            port_row[p]   = RowW'(word_addr[p] >> BankW);
            port_macro[p] = MacroIdxW'((word_addr[p] >> (BankW + RowW)) & AddrWidth'(NumRows - 1));
        end
    end

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                bank_req[b][p] = req_i[p] && (port_bank[p] == BankIdxW'(b));
            end
        end
    end

    // A port targets a single bank, so OR-ing the bank grants gives at most one per port.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NumBanks; b++) gnt_o = gnt_o | bank_gnt[b];
    end

    always_comb begin
        bank_act   = '0;
        bank_we    = '0;
        bank_be    = '0;
        bank_wdata = '0;
        bank_row   = '0;
        bank_macro = '0;
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                if (bank_gnt[b][p]) begin
                    bank_act[b]   = 1'b1;
                    bank_we[b]    = we_i[p];
                    bank_be[b]    = be_i[p];
                    bank_wdata[b] = wdata_i[p];
                    bank_row[b]   = port_row[p];
                    bank_macro[b] = port_macro[p];
                end
            end
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        obi_bank_rr_arbiter #(
            .NumPorts (NumPorts)
        ) i_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (bank_req[b]),
            .gnt_o (bank_gnt[b])
        );

        for (genvar r = 0; r < NumRows; r++) begin : g_row
            logic mac_req;
            assign mac_req = bank_act[b] && (bank_macro[b] == MacroIdxW'(r));

            tc_sram #(
                .NumWords  (WordsPerMacro),
                .DataWidth (DataWidth),
                .Latency   (SramLatency)
            ) i_sram (
                .clk_i   (clk_i),
                .req_i   (mac_req),
                .we_i    (bank_we[b]),
                .addr_i  (bank_row[b]),
                .wdata_i (bank_wdata[b]),
                .be_i    (bank_be[b]),
                .rdata_o (sram_rdata[b][r])
            );
        end
    end

    always_comb begin
        resp_new = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (gnt_o[p]) begin
                resp_new[p].valid = 1'b1;
                resp_new[p].we    = we_i[p];
                resp_new[p].bank  = MaxBankW'(port_bank[p]);
                resp_new[p].macro = MaxMacroW'(port_macro[p]);
                resp_new[p].id    = MaxIdW'(aid_i[p]);
            end
        end
    end

    // Response shift register, aligned with the macro read latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                resp_q[p][1] <= resp_new[p];
                for (int s = 2; s <= SramLatency; s++) resp_q[p][s] <= resp_q[p][s-1];
            end
        end
    end

    always_comb begin
        resp_out = '0;
        rvalid_o = '0;
        rdata_o  = '0;
        rid_o    = '0;
        for (int p = 0; p < NumPorts; p++) begin
            resp_out[p] = resp_q[p][SramLatency];
            rvalid_o[p] = resp_out[p].valid;
            if (resp_out[p].valid) begin
                rid_o[p] = resp_out[p].id[IdWidth-1:0];
                if (!resp_out[p].we) begin
                    rdata_o[p] = sram_rdata[resp_out[p].bank[BankIdxW-1:0]][resp_out[p].macro[MacroIdxW-1:0]];
                end
            end
        end
    end

    assign conflict = |(req_i & ~gnt_o);

    always_ff @(posedge clk_i) begin
        if (rst_i || conflict_clr_i) begin
            conflict_cnt_q <= '0;
        end else if (conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;

    // Entry fields wider than this configuration needs are intentionally dropped.
    logic unused_resp;
    assign unused_resp = ^resp_q;

`ifndef SYNTHESIS
    for (genvar p = 0; p < NumPorts; p++) begin : g_obi_stable
        assert property (@(posedge clk_i) disable iff (rst_i)
            (req_i[p] && !gnt_o[p]) |=> $stable({addr_i[p], we_i[p], be_i[p], wdata_i[p], aid_i[p]}))
            else $error("obi port %0d changed its request while waiting for gnt", p);
    end
`endif

endmodule

// File: tb/tb_obi_sram_banked_ctrl.sv
// Directed bench for obi_sram_banked_ctrl: one instance at latency 1 and one at
// latency 2 share the same stimulus.
module tb_obi_sram_banked_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req, gnt, gnt2, we, rvalid, rvalid2;
    logic [1:0][31:0]  addr;
    logic [1:0][7:0]   be;
    logic [1:0][63:0]  wdata, rdata, rdata2;
    logic [1:0][1:0]   aid, rid, rid2;
    logic              clr;
    logic [31:0]       cnt, cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    obi_sram_banked_ctrl #(
        .NumPorts (2), .NumBanks (4), .NumRows (2), .WordsPerMacro (256),
        .DataWidth (64), .AddrWidth (32), .IdWidth (2), .SramLatency (1)
    ) dut (
        .clk_i (clk), .rst_i (rst), .req_i (req), .gnt_o (gnt), .addr_i (addr),
        .we_i (we), .be_i (be), .wdata_i (wdata), .aid_i (aid), .rvalid_o (rvalid),
        .rdata_o (rdata), .rid_o (rid), .conflict_clr_i (clr), .conflict_cnt_o (cnt)
    );

    obi_sram_banked_ctrl #(
        .NumPorts (2), .NumBanks (4), .NumRows (2), .WordsPerMacro (256),
        .DataWidth (64), .AddrWidth (32), .IdWidth (2), .SramLatency (2)
    ) dut2 (
        .clk_i (clk), .rst_i (rst), .req_i (req), .gnt_o (gnt2), .addr_i (addr),
        .we_i (we), .be_i (be), .wdata_i (wdata), .aid_i (aid), .rvalid_o (rvalid2),
        .rdata_o (rdata2), .rid_o (rid2), .conflict_clr_i (clr), .conflict_cnt_o (cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [63:0] d, input logic [1:0] id);
        req[p]   = r;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        aid[p]   = id;
    endtask

    localparam logic [63:0] W1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
    localparam logic [63:0] P0 = 64'hA5A5_0000_FFFF_0001;
    localparam logic [63:0] P1 = 64'h5A5A_1234_0000_FFFE;

    initial begin
        rst = 1'b1; clr = 1'b0; req = '0; we = '0; addr = '0;
        be = {8'hFF, 8'hFF}; wdata = '0; aid = '0;

        // Reset: no grant even with a request pending
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h40, 64'h0, 2'd0); #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        @(negedge clk); req = '0;

        // Single write then read, both latencies
        @(negedge clk); rst = 1'b0; drive(0, 1'b1, 1'b1, 32'h2008, W1, 2'd0); #1;
        chk("s1_wr_gnt", 64'(gnt), 64'h1);
        chk("s1_wr_gnt_l2", 64'(gnt2), 64'h1);
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h2008, 64'h0, 2'd1); #1;
        chk("s1_rd_gnt", 64'(gnt), 64'h1);
        chk("s1_wr_rvalid", 64'(rvalid), 64'h1);
        chk("s1_wr_rdata", rdata[0], 64'h0);
        chk("s1_l2_wr_early", 64'(rvalid2), 64'h0);
        @(negedge clk); req = '0; #1;
        chk("s1_rd_rvalid", 64'(rvalid), 64'h1);
        chk("s1_rd_rdata", rdata[0], W1);
        chk("s1_rd_rid", 64'(rid[0]), 64'h1);
        chk("s1_l2_wr_rvalid", 64'(rvalid2), 64'h1);
        chk("s1_l2_wr_rdata", rdata2[0], 64'h0);
        @(negedge clk); #1;
        chk("s1_idle_rvalid", 64'(rvalid), 64'h0);
        chk("s1_idle_rdata", rdata[0], 64'h0);
        chk("s1_l2_rd_rvalid", 64'(rvalid2), 64'h1);
        chk("s1_l2_rd_rdata", rdata2[0], W1);
        chk("s1_l2_rd_rid", 64'(rid2[0]), 64'h1);
        @(negedge clk); #1;
        chk("s1_l2_idle", 64'(rvalid2), 64'h0);

        // Different banks in parallel
        @(negedge clk); drive(0, 1'b1, 1'b1, 32'h00, DA, 2'd2); drive(1, 1'b1, 1'b1, 32'h08, DB, 2'd3); #1;
        chk("s2_wr_gnt", 64'(gnt), 64'h3);
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h00, 64'h0, 2'd2); drive(1, 1'b1, 1'b0, 32'h08, 64'h0, 2'd3); #1;
        chk("s2_rd_gnt", 64'(gnt), 64'h3);
        chk("s2_wr_rvalid", 64'(rvalid), 64'h3);
        @(negedge clk); req = '0; #1;
        chk("s2_rd_rvalid", 64'(rvalid), 64'h3);
        chk("s2_rdata0", rdata[0], DA);
        chk("s2_rdata1", rdata[1], DB);
        chk("s2_rid1", 64'(rid[1]), 64'h3);
        chk("s2_cnt", 64'(cnt), 64'h0);

        // Both ports on bank2: grants alternate, one conflict per cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                drive(0, 1'b1, 1'b0, 32'h10, 64'h0, 2'd0);
                drive(1, 1'b1, 1'b0, 32'h30, 64'h0, 2'd1);
            end
            #1;
            chk($sformatf("s3_gnt_%0d", i), 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        @(negedge clk); req = '0; #1;
        chk("s3_cnt", 64'(cnt), 64'h6);

        // Macro select: same bank/row, macro 0 vs 1
        @(negedge clk); drive(0, 1'b1, 1'b1, 32'h0000, P0, 2'd0);
        @(negedge clk); drive(0, 1'b1, 1'b1, 32'h2000, P1, 2'd0);
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h0000, 64'h0, 2'd2); #1;
        chk("s4_rd0_gnt", 64'(gnt), 64'h1);
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h2000, 64'h0, 2'd3); #1;
        chk("s4_rd0_rvalid", 64'(rvalid), 64'h1);
        chk("s4_rd0_rdata", rdata[0], P0);
        chk("s4_rd0_rid", 64'(rid[0]), 64'h2);
        @(negedge clk); req = '0; #1;
        chk("s4_rd1_rvalid", 64'(rvalid), 64'h1);
        chk("s4_rd1_rdata", rdata[0], P1);
        chk("s4_rd1_rid", 64'(rid[0]), 64'h3);

        // Reset in the cycle after a read grant drops the in-flight response
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h0000, 64'h0, 2'd1); #1;
        chk("s5_gnt", 64'(gnt), 64'h1);
        @(negedge clk); req = '0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("s5_rvalid", 64'(rvalid), 64'h0);
        chk("s5_l2_rvalid", 64'(rvalid2), 64'h0);
        chk("s5_cnt", 64'(cnt), 64'h0);
        chk("s5_l2_cnt", 64'(cnt2), 64'h0);
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h00, 64'h0, 2'd0); drive(1, 1'b1, 1'b0, 32'h20, 64'h0, 2'd1); #1;
        chk("s5_first_gnt", 64'(gnt), 64'h1);
        @(negedge clk); req[0] = 1'b0; #1;
        chk("s5_second_gnt", 64'(gnt), 64'h2);
        @(negedge clk); req = '0; #1;
        chk("s5_cnt_after", 64'(cnt), 64'h1);

        // Saturation, then clear winning over a simultaneous conflict
        @(negedge clk);
        force dut.conflict_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.conflict_cnt_q;
        chk("s6_preload", 64'(cnt), 64'hFFFF_FFFE);
        @(negedge clk); drive(0, 1'b1, 1'b0, 32'h18, 64'h0, 2'd0); drive(1, 1'b1, 1'b0, 32'h38, 64'h0, 2'd1); #1;
        chk("s6_gnt", 64'(gnt), 64'h1);
        @(negedge clk); #1;
        chk("s6_cnt1", 64'(cnt), 64'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk); req = '0; #1;
        chk("s6_cnt_sat", 64'(cnt), 64'hFFFF_FFFF);
        @(negedge clk); req = 2'b11; clr = 1'b1;
        @(negedge clk); req = '0; clr = 1'b0; #1;
        chk("s6_clr", 64'(cnt), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
